reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//  Receiving end of the board reset-request pulse (delay/width pulse generator output).
//  Synchronises the request into clk, holds a staged reset bus asserted for a minimum width,
//  waits for a stable clock-lock indication, then releases the stages in order and flags ready.
//  Handles lock timeout with bounded retry and a sticky fault state.
// PARAMETERS
//  SYNC_STAGES  2      flops in each input synchroniser (reset_req_i, lock_i), >=2
//  MIN_WIDTH    16     min cycles rst_o held after synchronised request deasserts, >=1
//  LOCK_STABLE  64     consecutive lock_sync-high cycles required before release, >=1
//  LOCK_TIMEOUT 65536  cycles in WAIT_LOCK before a retry is taken, >LOCK_STABLE
//  NUM_STAGES   4      number of staged reset outputs, 1..8
//  STAGE_GAP    8      cycles between successive stage releases, >=1
//  MAX_RETRY    3      lock retries before FAULT, 0..15
// PORTS
//  clk            in   1           system clock
//  async_reset_i  in   1           reset async_reset_i, asynchronous, active-high; clock clk
//  reset_req_i    in   1           reset request, asynchronous level/pulse from generator
//  lock_i         in   1           PLL/MMCM locked, asynchronous
//  rst_o          out  NUM_STAGES  staged resets, active-high, bit 0 released first
//  ready_o        out  1           all stages released, lock good
//  lock_err_o     out  1           sticky: retries exhausted (FAULT)
//  retry_cnt_o    out  4           retries taken since last request/RUN
//  state_o        out  3           0 ASSERT,1 WAIT_LOCK,2 RELEASE,3 RUN,4 FAULT
// BEHAVIOUR
//  - async_reset_i high: state ASSERT, rst_o all ones, ready_o 0, lock_err_o 0, retry_cnt_o 0,
//    all counters 0, synchroniser flops 0. All outputs registered.
//  - req_sync/lock_sync = last flop of SYNC_STAGES chain; req_sync high -> ASSERT next cycle
//    from ANY state: rst_o all ones, ready_o 0, lock_err_o 0, retry_cnt 0, width counter 0.
//    Latency reset_req_i rise -> rst_o all ones: SYNC_STAGES+1 cycles max.
//  - ASSERT: width counter counts only while req_sync low; held 0 while high. Count reaches
//    MIN_WIDTH-1 with req_sync low -> WAIT_LOCK. rst_o all ones.
//  - WAIT_LOCK: rst_o all ones. Stable counter +1 per lock_sync-high cycle, cleared on low.
//    Stable reaches LOCK_STABLE-1 -> RELEASE (stable wins if same cycle as timeout).
//    Timeout counter reaches LOCK_TIMEOUT-1: retry_cnt<MAX_RETRY -> retry_cnt+1, ASSERT;
//    else -> FAULT. Counters cleared on every entry.
//  - RELEASE: rst_o[k] deasserts at cycle (k+1)*STAGE_GAP after entry (entry cycle = 1);
//    stages stay released once dropped. Cycle after rst_o[NUM_STAGES-1] drops -> RUN.
//  - RUN: rst_o all zeros, ready_o 1, retry_cnt cleared on entry.
//  - lock_sync low in RELEASE or RUN -> ASSERT next cycle (rst_o all ones, ready_o 0);
//    retry_cnt unchanged, not incremented.
//  - FAULT: rst_o all ones, ready_o 0, lock_err_o 1; exits only via req_sync high or async reset.
//  - Simultaneous req_sync high and any other event: request has priority.
//  - Counters saturating-safe: width >= clog2(LOCK_TIMEOUT); no wrap in any state.
// TESTING
//  T1 power-up: async_reset_i 1->0, lock_i=1, req=0 -> ASSERT 16 cyc, WAIT_LOCK 64 cyc,
//     rst_o[0..3] drop at RELEASE cycles 8/16/24/32, RUN and ready_o=1 next cycle.
//  T2 request mid-RUN: reset_req_i pulse 5 cyc -> rst_o=4'hF within 3 cyc, held >=16 cyc
//     after req_sync falls, full release sequence repeats, retry_cnt_o=0.
//  T3 lock glitch in WAIT_LOCK: lock_i low 1 cyc at stable count 40 -> stable restarts,
//     release starts 64 cyc after glitch ends.
//  T4 lock never asserts, LOCK_TIMEOUT=256: retry_cnt_o 1,2,3 at each timeout, then FAULT,
//     lock_err_o=1, rst_o=4'hF; reset_req_i pulse -> lock_err_o=0, retry_cnt_o=0, ASSERT.
//  T5 lock loss during RELEASE after rst_o[0] dropped -> rst_o=4'hF next cycle, ASSERT,
//     retry_cnt_o unchanged; lock restored -> normal sequence to RUN.
//  T6 async_reset_i asserted mid-RELEASE -> all outputs to reset values immediately, no clk.

Source files
------------

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer : synchronises a board reset request, holds a staged reset
//                   bus for a minimum width, waits for stable PLL lock, then
//                   releases the stages in order. Lock timeout retries, sticky fault.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reset_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_WIDTH    = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int NUM_STAGES   = 4,
  parameter int STAGE_GAP    = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  async_reset_i,
  input  logic                  reset_req_i,
  input  logic                  lock_i,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic                  ready_o,
  output logic                  lock_err_o,
  output logic [3:0]            retry_cnt_o,
  output logic [2:0]            state_o
);

  localparam int C_REL_END_I = NUM_STAGES * STAGE_GAP;
  localparam int C_MAX_AB    = (LOCK_TIMEOUT > MIN_WIDTH) ? LOCK_TIMEOUT : MIN_WIDTH;
  localparam int C_CMAX      = (C_MAX_AB > C_REL_END_I) ? C_MAX_AB : C_REL_END_I;
  localparam int CW          = $clog2(C_CMAX + 1);

  localparam logic [CW-1:0] C_ONE        = CW'(1);
  localparam logic [CW-1:0] C_WIDTH_END  = CW'(MIN_WIDTH - 1);
  localparam logic [CW-1:0] C_STABLE_END = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] C_TMO_END    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_REL_END    = CW'(C_REL_END_I);
  localparam logic [3:0]    C_RETRY_MAX  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_WAIT    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  req_sync_q;
  logic [SYNC_STAGES-1:0]  lock_sync_q;
  logic [NUM_STAGES-1:0]   rst_q;
  logic                    ready_q;
  logic                    lock_err_q;
  logic [3:0]              retry_q;
  logic [CW-1:0]           width_q;
  logic [CW-1:0]           stab_q;
  logic [CW-1:0]           tmo_q;
  logic [CW-1:0]           rel_q;

  logic                    req_sync;
  logic                    lock_sync;
  logic [CW-1:0]           rel_cnt_d;
  logic [NUM_STAGES-1:0]   rel_mask_d;

  // Plain flop chains; the last flop of each is the only one consumed.
  always_ff @(posedge clk or posedge async_reset_i) begin
    if (async_reset_i) begin
      req_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], reset_req_i};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], lock_i};
    end
  end

  assign req_sync  = req_sync_q[SYNC_STAGES-1];
  assign lock_sync = lock_sync_q[SYNC_STAGES-1];

  // Release cycle numbering starts at 1 on the entry cycle.
  assign rel_cnt_d = (state_q == ST_RELEASE) ? (rel_q + C_ONE) : C_ONE;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam logic [CW-1:0] C_DROP = CW'((k + 1) * STAGE_GAP);
    assign rel_mask_d[k] = (rel_cnt_d < C_DROP);
  end

  always_ff @(posedge clk or posedge async_reset_i) begin
    if (async_reset_i) begin
      state_q    <= ST_ASSERT;
      rst_q      <= '1;
      ready_q    <= 1'b0;
      lock_err_q <= 1'b0;
      retry_q    <= '0;
      width_q    <= '0;
      stab_q     <= '0;
      tmo_q      <= '0;
      rel_q      <= '0;
    end else if (req_sync) begin
      state_q    <= ST_ASSERT;
      rst_q      <= '1;
      ready_q    <= 1'b0;
      lock_err_q <= 1'b0;
      retry_q    <= '0;
      width_q    <= '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_q   <= '1;
          ready_q <= 1'b0;
          if (width_q >= C_WIDTH_END) begin
            state_q <= ST_WAIT;
            stab_q  <= '0;
            tmo_q   <= '0;
          end else begin
            width_q <= width_q + C_ONE;
          end
        end

        ST_WAIT: begin
          rst_q <= '1;
          // Stable lock is tested first so it wins a tie with the timeout.
          if (lock_sync && (stab_q >= C_STABLE_END)) begin
            state_q <= ST_RELEASE;
            rel_q   <= rel_cnt_d;
            rst_q   <= rel_mask_d;
          end else if (tmo_q >= C_TMO_END) begin
            if (retry_q < C_RETRY_MAX) begin
              retry_q <= retry_q + 4'd1;
              state_q <= ST_ASSERT;
              width_q <= '0;
            end else begin
              state_q    <= ST_FAULT;
              lock_err_q <= 1'b1;
            end
          end else begin
            tmo_q  <= tmo_q + C_ONE;
            stab_q <= lock_sync ? (stab_q + C_ONE) : '0;
          end
        end

        ST_RELEASE: begin
          if (!lock_sync) begin
            state_q <= ST_ASSERT;
            rst_q   <= '1;
            width_q <= '0;
          end else if (rel_q >= C_REL_END) begin
            state_q <= ST_RUN;
            rst_q   <= '0;
            ready_q <= 1'b1;
            retry_q <= '0;
          end else begin
            rel_q <= rel_cnt_d;
            rst_q <= rst_q & rel_mask_d;
          end
        end

        ST_RUN: begin
          if (!lock_sync) begin
            state_q <= ST_ASSERT;
            rst_q   <= '1;
            ready_q <= 1'b0;
            width_q <= '0;
          end
        end

        ST_FAULT: begin
          rst_q      <= '1;
          ready_q    <= 1'b0;
          lock_err_q <= 1'b1;
        end

        default: begin
          state_q <= ST_ASSERT;
          rst_q   <= '1;
          ready_q <= 1'b0;
          width_q <= '0;
        end
      endcase
    end
  end

  assign rst_o       = rst_q;
  assign ready_o     = ready_q;
  assign lock_err_o  = lock_err_q;
  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;

endmodule

`default_nettype wire
